mux_4x1: RTL and testbench
==========================

Name: mux_4x1

Overview:
- Registered 4-to-1 multiplexer. Two select bits pick one of four equal-width data inputs.
- The chosen input is captured into an output register on the rising clock edge.
- Used as a generic datapath selector wherever a 4-way choice with one-cycle registered timing is needed.
- The default width is 1 bit (single-bit mux).

Parameters:
- WIDTH, 1, bit width of each data input and of the output.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  capture enable; output register loads only when high
- sel1  input  1  select MSB
- sel0  input  1  select LSB
- in0  input  WIDTH  data input, chosen when {sel1,sel0}=00
- in1  input  WIDTH  data input, chosen when {sel1,sel0}=01
- in2  input  WIDTH  data input, chosen when {sel1,sel0}=10
- in3  input  WIDTH  data input, chosen when {sel1,sel0}=11
- out  output  WIDTH  registered mux result
- out_valid  output  1  high for the cycle(s) after a capture; marks out as fresh
- out_comb  output  WIDTH  unregistered mux result, for same-cycle use

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Select encoding: {sel1,sel0} 00→in0, 01→in1, 10→in2, 11→in3. sel1 is the MSB.
- out_comb: purely combinational, out_comb = selected input. It follows input and select changes within the same cycle. It is not affected by rst or en.
- Reset: when rst=1 at a rising clk edge, out ← 0 (all WIDTH bits) and out_valid ← 0.
  - rst has priority over en.
  - Reset asserted mid-stream discards the pending capture.
- Capture: when rst=0 and en=1 at a rising edge, out ← out_comb and out_valid ← 1.
  - Latency is exactly 1 clock from sampled inputs/select to out.
- Hold: when rst=0 and en=0, out holds its previous value and out_valid ← 0.
- Back-to-back: en held high gives a new result every cycle. out_valid stays high continuously.
- Select or data changes between edges have no effect on out until the next enabled edge.
- No X-propagation special handling. Select bits are treated as 2-bit binary.
- Width: all data paths are exactly WIDTH bits. There is no extension or truncation.

Decomposition:
- Shared package mux_pkg holds:
  - localparam select codes SEL_IN0=2'b00, SEL_IN1=2'b01, SEL_IN2=2'b10, SEL_IN3=2'b11
  - a typedef for the 2-bit select code
- One natural sub-module: mux4_comb.
  - Parameterized by WIDTH; purely combinational case on {sel1,sel0}; drives out_comb.
  - The top instantiates mux4_comb and adds the output register and the valid flop.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs → out=0 and out_valid=0.
- Select 00: sel1=0, sel0=0, in0=1, in1=in2=in3=0, en=1 → out_comb=1 immediately; out=1 and out_valid=1 after one edge.
- Select 01: sel1=0, sel0=1, in1=1, others 0, en=1 → out=1 after one edge. Then set in1=0 with the same select → out=0 on the next edge.
- Selects 10 and 11:
  - sel1=1, sel0=0, in2=1, others 0 → out=1.
  - sel1=1, sel0=1, in3=1, others 0 → out=1.
  - Also drive in0=1, in3=0 with select 11 → out=0, proving no leakage from unselected inputs.
- Enable/hold:
  - Capture out=1, then set en=0 and change to select 00 with in0=0 → out stays 1 and out_valid=0.
  - Raise en → out=0 the next cycle.
- Reset priority: rst=1 and en=1 in the same cycle with select 11, in3=1 → out=0 and out_valid=0. Repeat with WIDTH=8: in0..in3 = 8'hA5, 8'h3C, 8'hF0, 8'h0F → each select returns the matching byte.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared select encoding for the 4-way selector.
// Imported by the combinational core and the registered top.
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_IN0 = 2'b00;
  localparam sel_t SEL_IN1 = 2'b01;
  localparam sel_t SEL_IN2 = 2'b10;
  localparam sel_t SEL_IN3 = 2'b11;

endpackage

// File: rtl/mux4_comb.sv
// Purely combinational 4-to-1 selector core.
// sel is {sel1,sel0}; sel1 is the MSB.
module mux4_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  sel_t             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = in0;
    unique case (sel)
      SEL_IN0: y = in0;
      SEL_IN1: y = in1;
      SEL_IN2: y = in2;
      SEL_IN3: y = in3;
    endcase
  end

endmodule

// File: rtl/mux_4x1.sv
// Registered 4-to-1 mux with a fresh-data flag.
// out_comb is the same-cycle selection, out its one-cycle registered copy.
module mux_4x1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sel1,
  input  logic             sel0,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_comb
);

  sel_t sel;

  assign sel = {sel1, sel0};

  mux4_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .sel(sel),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .y  (out_comb)
  );

  // out_valid only marks the cycle after a capture; out itself holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) begin
        out <= out_comb;
      end
    end
  end

endmodule

// File: tb/tb_mux_4x1.sv
// Scoreboard bench for mux_4x1 at WIDTH=8 and WIDTH=1.
// The driver predicts each edge; a monitor checks after it.
module tb_mux_4x1;

  typedef struct {
    logic       v;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, sel1, sel0;
  logic [7:0] in0, in1, in2, in3;
  logic [7:0] out8, comb8;
  logic       vld8;
  logic       out1, comb1, vld1;

  int checks = 0;
  int passed = 0;

  exp_t       q[$];
  logic [7:0] ref_out = '0;
  bit         done = 1'b0;

  always #5 clk = ~clk;

  mux_4x1 #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .en(en),
    .sel1(sel1), .sel0(sel0),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out(out8), .out_valid(vld8), .out_comb(comb8)
  );

  mux_4x1 u1 (
    .clk(clk), .rst(rst), .en(en),
    .sel1(sel1), .sel0(sel0),
    .in0(in0[0]), .in1(in1[0]), .in2(in2[0]), .in3(in3[0]),
    .out(out1), .out_valid(vld1), .out_comb(comb1)
  );

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] s,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    logic [7:0] pick [4];
    exp_t x;
    rst = r; en = e; {sel1, sel0} = s;
    in0 = a; in1 = b; in2 = c; in3 = d;
    pick[0] = a; pick[1] = b; pick[2] = c; pick[3] = d;
    #1;
    chk("out_comb8", comb8, pick[s]);
    chk("out_comb1", {7'd0, comb1}, {7'd0, pick[s][0]});
    if (r) begin
      ref_out = '0;
      x.v = 1'b0;
    end else if (e) begin
      ref_out = pick[s];
      x.v = 1'b1;
    end else begin
      x.v = 1'b0;
    end
    x.d = ref_out;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("out8", out8, x.d);
        chk("out_valid8", {7'd0, vld8}, {7'd0, x.v});
        chk("out1", {7'd0, out1}, {7'd0, x.d[0]});
        chk("out_valid1", {7'd0, vld1}, {7'd0, x.v});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [1:0] s;
    step(1, 1, 2'b10, 8'h5A, 8'hC3, 8'h7E, 8'h81);
    step(1, 0, 2'b01, 8'hFF, 8'h00, 8'h12, 8'h34);
    step(0, 1, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00);
    step(0, 1, 2'b01, 8'h00, 8'h01, 8'h00, 8'h00);
    step(0, 1, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00);
    step(0, 1, 2'b10, 8'h00, 8'h00, 8'h01, 8'h00);
    step(0, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01);
    step(0, 1, 2'b11, 8'h01, 8'h00, 8'h00, 8'h00);
    step(0, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01);
    step(0, 0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    step(0, 0, 2'b01, 8'h00, 8'hFE, 8'h00, 8'h00);
    step(0, 1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    step(0, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01);
    step(1, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01);
    for (int i = 0; i < 4; i++)
      step(0, 1, 2'(i), 8'hA5, 8'h3C, 8'hF0, 8'h0F);
    step(0, 0, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44);
    for (int i = 0; i < 300; i++) begin
      s = 2'($urandom_range(3));
      step(($urandom_range(9) == 0), ($urandom_range(3) != 0), s,
           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    step(0, 0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d left, required 0", q.size());
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
